// File: rtl/ht_serial_pkg.sv
// Shared types and constants for the HT-series serial transmitter.
// Optional parity (macro HT_SERIAL_PARITY_EN) is handled in ht_serial_tx.
package ht_serial_pkg;

   localparam int unsigned HALF_DIV_DEF = 25;
   localparam int unsigned GAP_CYC_DEF  = 2;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SCLK_HI,
      SCLK_LO,
      GAP
   } state_e;

   // Bits needed to hold values 0..n
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ht_sclk_div.sv
// Phase-length down counter: a load of V gives a phase of V cycles, with
// tc_c high in the last one. Used for SCLK half-periods and the frame gap.
module ht_sclk_div #(
   parameter int unsigned CW = 5
) (
   input  logic          clk_50m,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   input  logic          clr_i,
   output logic          tc_c
);

   logic [CW-1:0] cnt_q, cnt_d;

   // Saturates at zero so a one-cycle phase never wraps
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i - CW'(1);
      end else if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/ht_serial_tx.sv
// Serial transmitter for HT shift-register peripherals (SCLK/SLOAD/SDATA).
// Define HT_SERIAL_PARITY_EN to append an even-parity bit to every frame.
module ht_serial_tx
   import ht_serial_pkg::*;
#(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned HALF_DIV  = HALF_DIV_DEF,
   parameter int unsigned GAP_CYC   = GAP_CYC_DEF,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              clk_50m,
   input  logic              rst_n,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_done,
   output logic              busy,
   output logic              HT_SCLK,
   output logic              HT_SLOAD,
   output logic              HT_SDATA
);

`ifdef HT_SERIAL_PARITY_EN
   localparam int unsigned NBITS = DATA_W + 1;
`else
   localparam int unsigned NBITS = DATA_W;
`endif
   localparam int unsigned BCW     = cnt_width(NBITS);
   localparam int unsigned DIV_MAX = (HALF_DIV > GAP_CYC) ? HALF_DIV : GAP_CYC;
   localparam int unsigned CW      = cnt_width(DIV_MAX);

   state_e            state_q, state_d;
   logic [NBITS-1:0]  sh_q, sh_d;
   logic [BCW-1:0]    bitcnt_q, bitcnt_d;
   logic              sclk_q, sclk_d;
   logic              sload_q, sload_d;
   logic              sdata_q, sdata_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              div_load;
   logic [CW-1:0]     div_val;
   logic              div_clr;
   logic              div_tc;

   logic [DATA_W-1:0] data_ord;
   logic [NBITS-1:0]  frame_word;

   // Shift register always emits from its MSB, so LSB-first payloads are reversed on load
   always_comb begin
      data_ord = tx_data;
      if (!MSB_FIRST) begin
         for (int i = 0; i < int'(DATA_W); i++) begin
            data_ord[i] = tx_data[DATA_W-1-i];
         end
      end
   end

`ifdef HT_SERIAL_PARITY_EN
   assign frame_word = {data_ord, ^tx_data};
`else
   assign frame_word = data_ord;
`endif

   ht_sclk_div #(
      .CW (CW)
   ) u_div (
      .clk_50m    (clk_50m),
      .rst_n      (rst_n),
      .load_i     (div_load),
      .load_val_i (div_val),
      .clr_i      (div_clr),
      .tc_c       (div_tc)
   );

   // Next state; pin values are computed for the coming state and registered
   always_comb begin
      state_d  = state_q;
      sh_d     = sh_q;
      bitcnt_d = bitcnt_q;
      sclk_d   = sclk_q;
      sload_d  = sload_q;
      sdata_d  = sdata_q;
      ready_d  = ready_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      div_load = 1'b0;
      div_val  = CW'(HALF_DIV);
      div_clr  = 1'b0;

      case (state_q)
         IDLE: begin
            if (tx_valid) begin
               state_d  = SETUP;
               sh_d     = frame_word;
               bitcnt_d = BCW'(NBITS);
               sload_d  = 1'b0;
               sdata_d  = frame_word[NBITS-1];
               ready_d  = 1'b0;
               busy_d   = 1'b1;
               div_load = 1'b1;
            end else begin
               div_clr = 1'b1;
            end
         end
         SETUP: begin
            if (div_tc) begin
               state_d  = SCLK_HI;
               sclk_d   = 1'b1;
               div_load = 1'b1;
            end
         end
         SCLK_HI: begin
            if (div_tc) begin
               state_d  = SCLK_LO;
               sclk_d   = 1'b0;
               div_load = 1'b1;
               bitcnt_d = bitcnt_q - BCW'(1);
               // Data advances on the falling edge, except after the final bit
               if (bitcnt_q != BCW'(1)) begin
                  sh_d    = sh_q << 1;
                  sdata_d = sh_d[NBITS-1];
               end
            end
         end
         SCLK_LO: begin
            if (div_tc) begin
               div_load = 1'b1;
               if (bitcnt_q == '0) begin
                  state_d = GAP;
                  sload_d = 1'b1;
                  sdata_d = 1'b1;
                  div_val = CW'(GAP_CYC);
               end else begin
                  state_d = SCLK_HI;
                  sclk_d  = 1'b1;
               end
            end
         end
         GAP: begin
            if (div_tc) begin
               state_d = IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sh_q     <= '0;
         bitcnt_q <= '0;
         sclk_q   <= 1'b0;
         sload_q  <= 1'b1;
         sdata_q  <= 1'b1;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sh_q     <= sh_d;
         bitcnt_q <= bitcnt_d;
         sclk_q   <= sclk_d;
         sload_q  <= sload_d;
         sdata_q  <= sdata_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign tx_ready = ready_q;
   assign busy     = busy_q;
   assign tx_done  = done_q;
   assign HT_SCLK  = sclk_q;
   assign HT_SLOAD = sload_q;
   assign HT_SDATA = sdata_q;

endmodule

// File: tb/tb_ht_serial_tx.sv
// Directed bench for ht_serial_tx: default, LSB-first/8-bit and HALF_DIV=1 instances.
// Expected frame bits include the parity bit when HT_SERIAL_PARITY_EN is defined.
module tb_ht_serial_tx;

`ifdef HT_SERIAL_PARITY_EN
   localparam int PX = 1;
`else
   localparam int PX = 0;
`endif
   localparam int H0 = 25, G0 = 2, N0 = 16 + PX;
   localparam int H1 = 3,  G1 = 2, N1 = 8 + PX;
   localparam int H2 = 1,  G2 = 1, N2 = 4 + PX;

   typedef struct {
      int          k;
      logic [31:0] data;
      logic [32:0] bits;
      int          rises, hi, low, tail, lat;
   } vec_t;

   typedef struct {
      logic [32:0] bits;
      int          rises, hi, low, lead, tail, lat;
      bit          to;
   } res_t;

   logic        clk_50m = 1'b0;
   logic        rst_n;
   logic [2:0]  valid, ready, done, busy, sclk, sload, sdata;
   logic [15:0] data0;
   logic [7:0]  data1;
   logic [3:0]  data2;

   int cyc = 0;
   int n_cmp = 0;
   int n_fail = 0;
   int done_cnt0 = 0;

   always #10 clk_50m = ~clk_50m;
   always @(posedge clk_50m) cyc <= cyc + 1;
   always @(posedge clk_50m) if (done[0]) done_cnt0 <= done_cnt0 + 1;

   ht_serial_tx u0 (
      .clk_50m(clk_50m), .rst_n(rst_n), .tx_valid(valid[0]), .tx_ready(ready[0]),
      .tx_data(data0), .tx_done(done[0]), .busy(busy[0]),
      .HT_SCLK(sclk[0]), .HT_SLOAD(sload[0]), .HT_SDATA(sdata[0]));

   ht_serial_tx #(.DATA_W(8), .HALF_DIV(3), .GAP_CYC(2), .MSB_FIRST(1'b0)) u1 (
      .clk_50m(clk_50m), .rst_n(rst_n), .tx_valid(valid[1]), .tx_ready(ready[1]),
      .tx_data(data1), .tx_done(done[1]), .busy(busy[1]),
      .HT_SCLK(sclk[1]), .HT_SLOAD(sload[1]), .HT_SDATA(sdata[1]));

   ht_serial_tx #(.DATA_W(4), .HALF_DIV(1), .GAP_CYC(1), .MSB_FIRST(1'b1)) u2 (
      .clk_50m(clk_50m), .rst_n(rst_n), .tx_valid(valid[2]), .tx_ready(ready[2]),
      .tx_data(data2), .tx_done(done[2]), .busy(busy[2]),
      .HT_SCLK(sclk[2]), .HT_SLOAD(sload[2]), .HT_SDATA(sdata[2]));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int k, input logic [31:0] d,
                               input logic [31:0] pay, input logic par);
      vec_t v;
      int n, h, g;
      case (k)
         0:       begin n = N0; h = H0; g = G0; end
         1:       begin n = N1; h = H1; g = G1; end
         default: begin n = N2; h = H2; g = G2; end
      endcase
      v.k     = k;
      v.data  = d;
      v.bits  = (PX != 0) ? {pay, par} : {1'b0, pay};
      v.rises = n;
      v.hi    = n * h;
      v.low   = (2 * n + 1) * h;
      v.tail  = g + 1;
      v.lat   = 1 + v.low + g;
      return v;
   endfunction

   task automatic set_data(input int k, input logic [31:0] d);
      case (k)
         0:       data0 = d[15:0];
         1:       data1 = d[7:0];
         default: data2 = d[3:0];
      endcase
   endtask

   // Wait for ready, present a word for one accept edge (or keep valid high)
   task automatic send(input int k, input logic [31:0] d, input bit hold, output int c0);
      int n;
      n = 0;
      @(negedge clk_50m);
      while (!ready[k] && n < 3000) begin
         @(negedge clk_50m);
         n++;
      end
      chk($sformatf("k%0d ready before accept", k), 64'(ready[k]), 64'(1));
      set_data(k, d);
      valid[k] = 1'b1;
      c0 = cyc;
      @(posedge clk_50m);
      #1;
      if (!hold) valid[k] = 1'b0;
   endtask

   // Observe one frame from the cycle after accept up to and including tx_done
   task automatic watch(input int k, input int c0, output res_t r);
      logic prev;
      bit   seen;
      r.bits = '0; r.rises = 0; r.hi = 0; r.low = 0; r.lead = 0;
      r.tail = 0; r.lat = 0; r.to = 1'b1;
      prev = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk_50m);
         if (!sload[k]) begin
            r.low++;
            seen = 1'b1;
         end else if (!seen) r.lead++;
         else r.tail++;
         if (sclk[k]) begin
            r.hi++;
            if (!prev) begin
               r.bits = {r.bits[31:0], sdata[k]};
               r.rises++;
            end
         end
         prev = sclk[k];
         if (done[k]) begin
            r.lat = cyc - c0;
            r.to  = 1'b0;
            return;
         end
      end
   endtask

   task automatic check_res(input string nm, input res_t r, input vec_t v);
      chk({nm, " timeout"}, 64'(r.to), 64'(0));
      chk({nm, " bits"}, 64'(r.bits), 64'(v.bits));
      chk({nm, " sclk rises"}, 64'(r.rises), 64'(v.rises));
      chk({nm, " sclk high cycles"}, 64'(r.hi), 64'(v.hi));
      chk({nm, " sload low"}, 64'(r.low), 64'(v.low));
      chk({nm, " sload lead"}, 64'(r.lead), 64'(0));
      chk({nm, " sload tail"}, 64'(r.tail), 64'(v.tail));
      chk({nm, " latency"}, 64'(r.lat), 64'(v.lat));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv[7];
      res_t r, r2;
      int   c0, b0;

      tv[0] = mk(0, 32'hA5C3, 32'hA5C3, 1'b0);
      tv[1] = mk(0, 32'h0007, 32'h0007, 1'b1);
      tv[2] = mk(0, 32'h0003, 32'h0003, 1'b0);
      tv[3] = mk(1, 32'h01,   32'h80,   1'b1);
      tv[4] = mk(1, 32'hB4,   32'h2D,   1'b0);
      tv[5] = mk(2, 32'hA,    32'hA,    1'b0);
      tv[6] = mk(2, 32'h5,    32'h5,    1'b0);

      rst_n = 1'b0;
      valid = '0;
      data0 = '0; data1 = '0; data2 = '0;
      repeat (3) @(negedge clk_50m);
      for (int k = 0; k < 3; k++)
         chk($sformatf("k%0d reset idle {rdy,busy,done,sclk,sload,sdata}", k),
             64'({ready[k], busy[k], done[k], sclk[k], sload[k], sdata[k]}), 64'(6'b100011));
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         send(tv[i].k, tv[i].data, 1'b0, c0);
         watch(tv[i].k, c0, r);
         check_res($sformatf("vec%0d", i), r, tv[i]);
         @(negedge clk_50m);
         chk($sformatf("vec%0d done pulse width", i), 64'(done[tv[i].k]), 64'(0));
      end

      // Back-to-back with tx_valid held high across the tx_done cycle
      b0 = done_cnt0;
      send(0, 32'h0001, 1'b1, c0);
      set_data(0, 32'h8000);
      watch(0, c0, r);
      check_res("b2b first", r, mk(0, 32'h0001, 32'h0001, 1'b1));
      chk("b2b ready in done cycle", 64'(ready[0]), 64'(1));
      c0 = cyc;
      @(posedge clk_50m);
      #1;
      valid[0] = 1'b0;
      watch(0, c0, r2);
      check_res("b2b second", r2, mk(0, 32'h8000, 32'h8000, 1'b1));
      chk("b2b sload high gap", 64'(r.tail + r2.lead), 64'(G0 + 1));
      repeat (3) @(negedge clk_50m);
      chk("b2b done pulses", 64'(done_cnt0 - b0), 64'(2));

      // Asynchronous reset in the middle of a frame
      send(0, 32'h1234, 1'b0, c0);
      repeat (299) @(negedge clk_50m);
      chk("mid-frame {busy,sload}", 64'({busy[0], sload[0]}), 64'(2'b10));
      #3;
      rst_n = 1'b0;
      #1;
      chk("async reset idle {rdy,busy,done,sclk,sload,sdata}",
          64'({ready[0], busy[0], done[0], sclk[0], sload[0], sdata[0]}), 64'(6'b100011));
      @(negedge clk_50m);
      chk("reset held idle {rdy,busy,done,sclk,sload,sdata}",
          64'({ready[0], busy[0], done[0], sclk[0], sload[0], sdata[0]}), 64'(6'b100011));
      rst_n = 1'b1;
      send(0, 32'hFFFF, 1'b0, c0);
      watch(0, c0, r);
      check_res("after reset", r, mk(0, 32'hFFFF, 32'hFFFF, 1'b0));

      repeat (2) @(negedge clk_50m);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ht_serial_tx.md
# ht_serial_tx

Parametrised serial transmitter for HT-series shift-register peripherals, the successor to the fixed 16-bit SCLK/SLOAD/SDATA driver. It accepts words over a valid/ready handshake, frames each word with SLOAD low, and shifts it out on SDATA against a programmable-rate SCLK. Width, bit order, clock rate and inter-frame gap are configurable. It sits between the measurement/control logic and the board-level HT device pins.

## Interface
- DATA_W, 16, payload bits per frame (1..32)
- HALF_DIV, 25, clk_50m cycles per SCLK half-period (≥1; 25 gives 1 MHz)
- GAP_CYC, 2, minimum cycles SLOAD stays high between frames (≥1)
- MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first
- clk_50m  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- tx_valid  in  1  word available
- tx_ready  out  1  block idle and able to accept
- tx_data  in  DATA_W  word to send, sampled only on accept
- tx_done  out  1  one-cycle pulse at frame completion
- busy  out  1  frame in progress (inverse of tx_ready)
- HT_SCLK  out  1  serial clock, idles low
- HT_SLOAD  out  1  frame strobe, active low, idles high
- HT_SDATA  out  1  serial data, idles high

## Operation
- Accept: tx_valid & tx_ready on a clk_50m edge; tx_data latched into shift register, bit counter loaded with NBITS (DATA_W, or DATA_W+1 with parity).
- States: IDLE → SETUP → SCLK_HI ⇄ SCLK_LO → GAP → IDLE.
- IDLE: tx_ready=1, SCLK=0, SLOAD=1, SDATA=1.
- SETUP (HALF_DIV cycles): SLOAD=0, SCLK=0, SDATA=first bit.
- SCLK_HI (HALF_DIV cycles): SCLK=1, SDATA stable; device samples on rising edge.
- SCLK_LO (HALF_DIV cycles): SCLK=0; SDATA advances to next bit on the falling-edge cycle; after the last bit's low phase go to GAP.
- GAP (GAP_CYC cycles): SLOAD=1, SDATA=1, SCLK=0.
- tx_data changes and tx_valid while busy are ignored; no queueing.
- All outputs are registered; no combinational path from inputs to pins.

## Timing
- Reset (async, any state): tx_ready=1, busy=0, tx_done=0, SCLK=0, SLOAD=1, SDATA=1; state=IDLE, shift register cleared. Frame in progress is abandoned without completing.
- SLOAD falls on the cycle after accept; SLOAD low for exactly (2·NBITS+1)·HALF_DIV cycles.
- First SCLK rise HALF_DIV cycles after SLOAD fall; NBITS rising edges per frame, period 2·HALF_DIV, 50 % duty.
- tx_done and tx_ready rise together GAP_CYC cycles after SLOAD rises; tx_done lasts one cycle.
- Accept-to-done latency: 1 + (2·NBITS+1)·HALF_DIV + GAP_CYC cycles (826+2 = 828 at defaults... i.e. 1+825+2).
- Back-to-back: tx_valid held high is accepted in the tx_done cycle; SLOAD high exactly GAP_CYC+1 cycles between frames.
- HALF_DIV=1: SCLK toggles every cycle; counters must not underflow.

## Configuration
- HT_SERIAL_PARITY_EN defined: NBITS=DATA_W+1; after the payload, one even-parity bit (XOR of tx_data) is shifted out, always last regardless of MSB_FIRST.
- Undefined: NBITS=DATA_W, no parity bit; frame timing uses DATA_W.

## Structure
- Package ht_serial_pkg: state enum (IDLE, SETUP, SCLK_HI, SCLK_LO, GAP), width function for bit counter (clog2 of NBITS+1), default HALF_DIV/GAP_CYC constants.
- Sub-module ht_sclk_div: half-period tick counter (load/clear, terminal-count pulse), reused for GAP counting.

## Test plan
- Defaults, tx_data=16'hA5C3 → SDATA at 16 SCLK rises = 1010 0101 1100 0011; SLOAD low 825 cycles; tx_done 828 cycles after accept.
- MSB_FIRST=0, DATA_W=8, tx_data=8'h01 → first sampled bit 1, remaining seven 0; SLOAD low 17·HALF_DIV cycles.
- tx_valid held high, two words 16'h0001 then 16'h8000 → SLOAD high exactly 3 cycles between frames, second frame bits correct, two tx_done pulses.
- rst_n low at cycle 300 of a frame → all outputs at idle values same cycle; after release, new word 16'hFFFF sent fully correct.
- HT_SERIAL_PARITY_EN, tx_data=16'h0007 → 17 SCLK rises, last bit 1; tx_data=16'h0003 → last bit 0.
- HALF_DIV=1, GAP_CYC=1, DATA_W=4, tx_data=4'hA → SCLK toggles every cycle, bits 1,0,1,0, latency 1+9+1=11 cycles.
